serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor, the inverse-direction companion to the team's ripple full-adder blocks. It computes diff = a - b - bin one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It uses a start/busy/done handshake and also exposes the difference as a serial bit stream. It sits beside the adder blocks in the arithmetic library and trades area for WIDTH cycles of latency.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend, captured on the accepting edge
b  input  WIDTH  subtrahend, captured on the accepting edge
bin  input  1  borrow-in, captured on the accepting edge
busy  output  1  high while the subtraction is in progress (RUN)
done  output  1  one-cycle pulse, result valid
diff  output  WIDTH  difference, held until the next accepted start
bout  output  1  final borrow-out, held with diff
d_bit  output  1  current serial difference bit
d_valid  output  1  qualifies d_bit, one pulse per bit

Behaviour:
- Reset (asynchronous, active-high): state = IDLE. busy, done, diff, bout, d_bit, d_valid, internal shift registers, borrow flop and bit counter all go to 0. Applies immediately, including mid-RUN; the in-flight operation is discarded.
- States:
  - IDLE: start=1 on edge t latches a, b and bin into shift regs A, B and borrow flop; clears counter and diff; goes to RUN. busy=1 from edge t.
  - RUN: each edge t+k (k=1..WIDTH) feeds A[0], B[0] and borrow to the cell.
    - Cell result bit shifts into diff from the MSB side, giving final LSB alignment.
    - Borrow flop takes the cell borrow-out.
    - A and B shift right; counter increments.
    - d_bit = cell result bit, d_valid=1 for that cycle.
    - On edge t+WIDTH: goes to DONE; bout = final borrow; busy=0.
  - DONE: done=1 for exactly one cycle (between edges t+WIDTH and t+WIDTH+1). Unconditional return to IDLE. start is ignored in DONE.
- Latency: done asserted WIDTH cycles after the accepting edge. Throughput: one operation per WIDTH+2 cycles.
- start while busy or in DONE: ignored; operands unaffected; no queuing.
- a, b and bin may change freely after the accepting edge.
- Arithmetic (unsigned, modulo 2^WIDTH):
  - diff = (a - b - bin) mod 2^WIDTH.
  - bout = 1 iff a < b + bin, with b + bin evaluated at WIDTH+1 bits.
- d_bit order is LSB first; d_valid is high exactly WIDTH cycles per operation.
- diff and bout are not written during IDLE or DONE.
- Counter width is clog2(WIDTH+1).
- WIDTH=1: RUN lasts one cycle.

Decomposition:
- Shared package/include `arith_pkg`: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2. Encoding 2'd3 is illegal and returns to IDLE.
- One sub-module, `full_subtractor_1bit` (x, y, bin -> d, bout):
  - d = x^y^bin
  - bout = (~x&y) | (~x&bin) | (y&bin)
  - Gate-level, matching the full-adder cell style; instantiated once.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0 -> done 8 cycles after start; diff=0x02, bout=0; busy high exactly 8 cycles.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0.
- a=0xA5, b=0x00, bin=0 -> d_bit stream under d_valid = 1,0,1,0,0,1,0,1; diff=0xA5.
- Start 0x10-0x01. Pulse start with a=0xFF, b=0xFF at RUN cycle 4 and again in the DONE cycle -> diff=0x0F and bout=0 unchanged; no second done.
- Assert rst at RUN cycle 3 -> all outputs 0 within the reset cycle, state IDLE. After release, start 0x09-0x04 -> diff=0x05, normal timing.
- WIDTH=1: all 8 (a, b, bin) combinations -> diff/bout match the full-subtractor truth table; done one cycle after start.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// The controller state encoding is common to the serial adder and subtractor.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor: start/busy/done handshake,
// operands, held result and the serial difference stream.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             d_bit;
    logic             d_valid;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, d_bit, d_valid
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, d_bit, d_valid
    );
endinterface

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor cell x - y - bin, written in the same gate style
// as the ripple full-adder cell.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic x_n;
    logic xy_x;
    logic g_xn_y;
    logic g_xn_b;
    logic g_y_b;

    assign x_n    = ~x;
    assign xy_x   = x ^ y;
    assign d      = xy_x ^ bin;
    assign g_xn_y = x_n & y;
    assign g_xn_b = x_n & bin;
    assign g_y_b  = y & bin;
    assign bout   = g_xn_y | g_xn_b | g_y_b;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first,
// through a single full-subtractor cell with a registered borrow.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic             borrow_q,  borrow_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] diff_q,    diff_d;
    logic             bout_q,    bout_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             d_bit_q,   d_bit_d;
    logic             d_valid_q, d_valid_d;

    logic             cell_d;
    logic             cell_b;
    logic             last_bit;

    full_subtractor_1bit u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_b)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        d_bit_d   = d_bit_q;
        d_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    diff_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // New bit enters at the MSB so the word is LSB-aligned after WIDTH shifts.
                diff_d    = (diff_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
                borrow_d  = cell_b;
                a_d       = a_q >> 1;
                b_d       = b_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                d_bit_d   = cell_d;
                d_valid_d = 1'b1;
                if (last_bit) begin
                    bout_d  = cell_b;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            d_bit_q   <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            borrow_q  <= borrow_d;
            cnt_q     <= cnt_d;
            diff_q    <= diff_d;
            bout_q    <= bout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            d_bit_q   <= d_bit_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.diff    = diff_q;
    assign bus.bout    = bout_q;
    assign bus.d_bit   = d_bit_q;
    assign bus.d_valid = d_valid_q;
endmodule
